// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: serialises each set bit of a request vector into one index beat.
// Latency: first beat one cycle after acceptance; one beat per cycle while out_ready=1.
// Backpressure: beats hold stable while out_ready=0; in_ready=0 until the last beat drains. Option: ENC_MSB_FIRST_EN.
module seq_priority_encoder #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_zero
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]   state;
    logic [N-1:0] pend;
    logic [N-1:0] sel;
    logic [W-1:0] idx;
    logic         pend_none;
    logic         pend_one;

    // Later loop hits overwrite earlier ones, so the loop direction sets service order.
    always_comb begin
        idx = '0;
        sel = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
`else
        for (int i = N - 1; i >= 0; i--) begin
`endif
            if (pend[i]) begin
                idx = W'(i);
                sel = '0;
                sel[i] = 1'b1;
            end
        end
    end

    assign pend_none = (pend == '0);
    assign pend_one  = !pend_none && ((pend & (pend - {{(N-1){1'b0}}, 1'b1})) == '0);

    // pend can only be zero in EMIT when an all-zero vector was accepted.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign out_idx   = idx;
    assign out_last  = (state == EMIT) && (pend_one || pend_none);
    assign out_zero  = (state == EMIT) && pend_none;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pend  <= in_vec;
                        state <= EMIT;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (out_last) begin
                            pend  <= '0;
                            state <= IDLE;
                        end else begin
                            pend  <= pend & ~sel;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Bench for seq_priority_encoder: directed table, hand-written reset/busy sequences, random vectors vs a bit-list model.
module tb_seq_priority_encoder;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_vec = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_zero;

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    bit exp_zero;

    typedef struct {
        logic [3:0]      vec;
        int              n;
        logic [3:0][1:0] idx;   // expected indices, lowest first; idx[k] is beat k
        bit              zero;
    } vec_t;

    vec_t tbl[7];

    seq_priority_encoder #(.N(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_vec(in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx(out_idx),
        .out_last(out_last),
        .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: list every set bit in service order; an empty vector is one zero beat.
    task automatic model(input logic [3:0] vec);
        exp_q.delete();
        exp_zero = (vec == 4'b0000);
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
`ifdef ENC_MSB_FIRST_EN
                exp_q.push_front(i);
`else
                exp_q.push_back(i);
`endif
            end
        end
        if (exp_zero) exp_q.push_back(0);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 5 cycles then ready.
    task automatic run_vec(input logic [3:0] vec, input int mode, input bit hold);
        int k;
        int cyc;
        chk("accept_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_vec = vec;
        out_ready = 1'b0;
        tick();
        if (hold) in_vec = 4'b0001;
        else in_valid = 1'b0;
        k = 0;
        cyc = 0;
        while (k < exp_q.size() && cyc < 100) begin
            case (mode)
                0: out_ready = 1'b1;
                2: out_ready = (cyc >= 5);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            chk("beat_valid", int'(out_valid), 1);
            chk("busy_in_ready", int'(in_ready), 0);
            chk("beat_idx", int'(out_idx), exp_q[k]);
            chk("beat_last", int'(out_last), int'(k == exp_q.size() - 1));
            chk("beat_zero", int'(out_zero), int'(exp_zero));
            if (out_ready) k++;
            tick();
            cyc++;
        end
        if (k < exp_q.size()) chk("beat_timeout", k, exp_q.size());
        out_ready = 1'b0;
        chk("done_in_ready", int'(in_ready), 1);
        chk("done_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        tbl[0] = '{vec: 4'b0100, n: 1, idx: {2'd0, 2'd0, 2'd0, 2'd2}, zero: 1'b0};
        tbl[1] = '{vec: 4'b1011, n: 3, idx: {2'd0, 2'd3, 2'd1, 2'd0}, zero: 1'b0};
        tbl[2] = '{vec: 4'b0000, n: 1, idx: {2'd0, 2'd0, 2'd0, 2'd0}, zero: 1'b1};
        tbl[3] = '{vec: 4'b1000, n: 1, idx: {2'd0, 2'd0, 2'd0, 2'd3}, zero: 1'b0};
        tbl[4] = '{vec: 4'b1111, n: 4, idx: {2'd3, 2'd2, 2'd1, 2'd0}, zero: 1'b0};
        tbl[5] = '{vec: 4'b0110, n: 2, idx: {2'd0, 2'd0, 2'd2, 2'd1}, zero: 1'b0};
        tbl[6] = '{vec: 4'b0001, n: 1, idx: {2'd0, 2'd0, 2'd0, 2'd0}, zero: 1'b0};

        #2;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_zero", int'(out_zero), 0);
        tick();
        rst_n = 1'b1;
        tick();

        foreach (tbl[t]) begin
            exp_q.delete();
            exp_zero = tbl[t].zero;
            for (int k = 0; k < tbl[t].n; k++) begin
`ifdef ENC_MSB_FIRST_EN
                exp_q.push_back(int'(tbl[t].idx[tbl[t].n - 1 - k]));
`else
                exp_q.push_back(int'(tbl[t].idx[k]));
`endif
            end
            run_vec(tbl[t].vec, 0, 1'b0);
        end

        // Backpressure: 0110 stalled for 5 cycles must hold its first beat.
        model(4'b0110);
        run_vec(4'b0110, 2, 1'b0);

        // Zero vector followed by a normal one.
        model(4'b0000);
        run_vec(4'b0000, 0, 1'b0);
        model(4'b1000);
        run_vec(4'b1000, 0, 1'b0);

        // Full vector with a second request held during EMIT; it is taken only afterwards.
        model(4'b1111);
        run_vec(4'b1111, 0, 1'b1);
        model(4'b0001);
        run_vec(4'b0001, 0, 1'b0);

        // Reset mid-EMIT after two accepted beats.
        in_valid = 1'b1;
        in_vec = 4'b1111;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("pre_rst_valid", int'(out_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_idx", int'(out_idx), 0);
        chk("midrst_out_last", int'(out_last), 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_no_beat", int'(out_valid), 0);
        end
        out_ready = 1'b0;

        // Random vectors with random consumer readiness.
        for (int r = 0; r < 40; r++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            model(v);
            run_vec(v, 1, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
Sequential encoder, the encoder side of the decoder_2to4 path. It accepts a multi-hot request vector over a valid/ready handshake and emits the binary index of each set bit, one per output beat, lowest index first. Each served bit is cleared. The block feeds decoder_2to4-style consumers and arbitration logic in the MiniGPU datapath.

Parameters:
N, 4, request vector width; legal range 2..32.
W, $clog2(N) (2 for N=4), index width; derived localparam, not overridable.

Ports:
clk  input  1  system clock; rising edge active
rst_n  input  1  asynchronous active-low reset; deassertion synchronous to clk
in_valid  input  1  in_vec is valid
in_ready  output  1  block can accept a vector
in_vec  input  N  request vector; bit i is request i
out_valid  output  1  out_idx, out_last and out_zero are valid
out_ready  input  1  consumer accepts the current beat
out_idx  output  W  encoded index of the current request bit
out_last  output  1  current beat is the final beat for this vector
out_zero  output  1  accepted vector was all zeros (no-request beat)

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE; internal pend register = 0
  - in_ready=1
  - out_valid=0, out_idx=0, out_last=0, out_zero=0
- Reset mid-EMIT drops the pending vector. No beat is produced for it.
- A handshake fires when valid and ready are both 1 on a rising edge.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: pend<=in_vec; go to EMIT.
  - out_valid rises on the next cycle (latency is 1 cycle from acceptance to first beat).
- EMIT:
  - in_ready=0; in_valid is ignored.
  - out_valid=1. out_idx = index of the lowest set bit of pend.
  - out_last=1 when pend has exactly one set bit.
  - Outputs are combinational from pend, so they stay stable while out_ready=0.
  - On out_ready=1 with out_last=0: clear that bit in pend; stay in EMIT; next beat on the next cycle.
  - On out_ready=1 with out_last=1: pend<=0; go to IDLE.
  - in_ready is 1 again on the cycle after the last beat is accepted. There is no same-cycle bypass, so back-to-back vectors cost one idle cycle.
- Zero vector:
  - Accepting in_vec=0 produces exactly one beat: out_zero=1, out_idx=0, out_last=1.
  - out_zero=0 on all other beats.
- Beat count per vector = popcount(in_vec), or 1 when in_vec=0. Full vector (all ones) produces N beats: 0..N-1.
- States: IDLE, EMIT; 1-bit state register. Unused encodings are unreachable.
- out_valid must not drop while out_ready=0 (no beat is retracted).

Optional Feature:
ENC_MSB_FIRST_EN
- Defined: service order is highest set bit first. out_idx = index of the MSB set in pend. out_last, out_zero, handshake and latency are unchanged.
- Undefined (default): LSB-first order as above.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle -> all outputs immediately at reset values (in_ready=1, out_valid=0, out_idx=0). Release, then in_vec=4'b0100, out_ready=1 -> one beat, out_idx=2, out_last=1.
- Multi-hot: in_vec=4'b1011, out_ready=1 -> beats on 3 consecutive cycles: idx 0, 1, 3 with out_last=0, 0, 1. in_ready=1 one cycle later. With ENC_MSB_FIRST_EN: idx 3, 1, 0.
- Backpressure: in_vec=4'b0110, out_ready=0 for 5 cycles -> out_valid=1, out_idx=1 held stable, in_ready=0. Raise out_ready -> idx 1 then 2 (last).
- Zero vector: in_vec=4'b0000 -> single beat, out_zero=1, out_idx=0, out_last=1. Next vector 4'b1000 -> idx 3, out_zero=0.
- Full vector and ignore-while-busy: in_vec=4'b1111, then in_valid=1 with in_vec=4'b0001 held during EMIT -> idx 0, 1, 2, 3 only. The second vector is accepted in IDLE afterwards and yields idx 0.
- Reset mid-operation: in_vec=4'b1111, reset after 2 beats -> out_valid=0 at once. Post-release, no residual beats occur while in_valid=0.
